// File: rtl/microwave_pkg.sv
// rtl/microwave_pkg.sv - shared state encoding and defaults for the cook-cycle controller
package microwave_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        COOK  = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } mag_state_t;

    localparam int BEEP_CYCLES_DEFAULT = 3;

endpackage

// File: rtl/edge_detect.sv
// rtl/edge_detect.sv - single-register rising-edge detector for a level key input
module edge_detect (
    input  logic clk,
    input  logic clearn,
    input  logic d,
    output logic rise
);

    logic d_q;
    logic d_d;

    // next value of the key history is simply the current key level
    always_comb begin
        d_d = d;
    end

    // key history register, cleared by the synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!clearn) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d_d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/magnetron_control.sv
// rtl/magnetron_control.sv - cook-cycle FSM driving timer enable/clear, magnetron and beeper (optional MAGNETRON_BEEP_EN)
module magnetron_control
    import microwave_pkg::*;
#(
    parameter int BEEP_CYCLES = BEEP_CYCLES_DEFAULT
) (
    input  logic       CLK,
    input  logic       clearn,
    input  logic       start,
    input  logic       stop,
    input  logic       door_closed,
    input  logic       timer_done,
    output logic       mag_on,
    output logic       timer_enable,
    output logic       timer_clearn,
    output logic       beep,
    output logic [1:0] state
);

    logic       start_rise;
    logic       stop_rise;
    mag_state_t state_q;
    mag_state_t state_d;
    logic       clr_q;
    logic       clr_d;

`ifdef MAGNETRON_BEEP_EN
    localparam int              CW        = $clog2(BEEP_CYCLES + 1);
    localparam logic [CW-1:0]   BEEP_LAST = CW'(BEEP_CYCLES);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          beep_q;
    logic          beep_d;
`else
    // BEEP_CYCLES has no effect when the beeper is not built
    logic beep_cycles_unused;
    assign beep_cycles_unused = (BEEP_CYCLES != 0);
`endif

    edge_detect u_start_edge (
        .clk    (CLK),
        .clearn (clearn),
        .d      (start),
        .rise   (start_rise)
    );

    edge_detect u_stop_edge (
        .clk    (CLK),
        .clearn (clearn),
        .d      (stop),
        .rise   (stop_rise)
    );

    // next-state logic: key edges, door and timer_done steer the cook cycle
    always_comb begin
        state_d = state_q;
        clr_d   = 1'b0;
`ifdef MAGNETRON_BEEP_EN
        cnt_d   = '0;
        beep_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (stop_rise) begin
                    clr_d = 1'b1;
                end else if (start_rise && door_closed && !timer_done) begin
                    state_d = COOK;
                end
            end
            COOK: begin
                if (timer_done) begin
                    state_d = DONE;
`ifdef MAGNETRON_BEEP_EN
                    beep_d  = 1'b1;
`endif
                end else if (!door_closed || stop_rise) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (stop_rise) begin
                    state_d = IDLE;
                    clr_d   = 1'b1;
                end else if (start_rise && door_closed) begin
                    state_d = COOK;
                end
            end
            DONE: begin
`ifdef MAGNETRON_BEEP_EN
                if (start_rise || stop_rise) begin
                    state_d = IDLE;
                end else if ((cnt_q + CW'(1)) == BEEP_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d  = cnt_q + CW'(1);
                    beep_d = 1'b1;
                end
`else
                state_d = IDLE;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // state, clear pulse and beeper registers
    always_ff @(posedge CLK) begin
        if (!clearn) begin
            state_q <= IDLE;
            clr_q   <= 1'b0;
`ifdef MAGNETRON_BEEP_EN
            cnt_q   <= '0;
            beep_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
`ifdef MAGNETRON_BEEP_EN
            cnt_q   <= cnt_d;
            beep_q  <= beep_d;
`endif
        end
    end

`ifdef MAGNETRON_BEEP_EN
    assign beep = beep_q;
`else
    assign beep = 1'b0;
`endif

    // door and timer_done act combinationally so the magnetron and timer stop at once
    assign mag_on       = (state_q == COOK) & door_closed;
    assign timer_enable = (state_q == COOK) & door_closed & ~timer_done;
    assign timer_clearn = clearn & ~clr_q;
    assign state        = state_q;

endmodule

// File: tb/tb_magnetron_control.sv
// tb/tb_magnetron_control.sv - self-checking bench for magnetron_control
module tb_magnetron_control;

    localparam int BEEP_CYCLES = 3;
`ifdef MAGNETRON_BEEP_EN
    localparam bit BEEP_ON = 1'b1;
`else
    localparam bit BEEP_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       clearn;
    logic       start;
    logic       stop;
    logic       door_closed;
    logic       timer_done;
    logic       mag_on;
    logic       timer_enable;
    logic       timer_clearn;
    logic       beep;
    logic [1:0] state;

    int checks   = 0;
    int failures = 0;

    magnetron_control #(.BEEP_CYCLES(BEEP_CYCLES)) dut (
        .CLK          (clk),
        .clearn       (clearn),
        .start        (start),
        .stop         (stop),
        .door_closed  (door_closed),
        .timer_done   (timer_done),
        .mag_on       (mag_on),
        .timer_enable (timer_enable),
        .timer_clearn (timer_clearn),
        .beep         (beep),
        .state        (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       c, s, p, d, td;
        logic [1:0] st;
        logic       mag, en, clrn, bp;
    } vec_t;

    vec_t tbl[20];

    // behavioural model: 0=idle 1=cook 2=pause 3=done
    int m_st;
    bit m_sq, m_pq, m_clr, m_beep;
    int m_left;
    int tcount;

    logic       a_en, a_beep, a_clrn;
    logic [1:0] a_st;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic c, s, p, d, td, input logic [1:0] st,
                                input logic mag, en, clrn, bp);
        vec_t v;
        v.c = c; v.s = s; v.p = p; v.d = d; v.td = td;
        v.st = st; v.mag = mag; v.en = en; v.clrn = clrn; v.bp = bp;
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        clearn = 1'b0; start = 1'b0; stop = 1'b0; door_closed = 1'b1; timer_done = 1'b1;
        m_st = 0; m_sq = 0; m_pq = 0; m_clr = 0; m_beep = 0; m_left = 0; tcount = 0;
    endtask

    // one cycle: drive, compare against model, advance model and timer to the next edge
    task automatic step(input bit s, input bit p, input bit d, input bit c);
        bit td, e_mag, e_en, e_clrn, sr, pr, nclr, nbeep;
        @(negedge clk);
        td = (tcount == 0);
        start = s; stop = p; door_closed = d; clearn = c; timer_done = td;
        #1;
        e_mag  = (m_st == 1) && d;
        e_en   = e_mag && !td;
        e_clrn = c && !m_clr;
        check("state", {30'd0, state}, m_st);
        check("mag_on", {31'd0, mag_on}, {31'd0, e_mag});
        check("timer_enable", {31'd0, timer_enable}, {31'd0, e_en});
        check("timer_clearn", {31'd0, timer_clearn}, {31'd0, e_clrn});
        check("beep", {31'd0, beep}, {31'd0, m_beep});
        a_en = timer_enable; a_beep = beep; a_clrn = timer_clearn; a_st = state;
        if (!c) begin
            m_st = 0; m_sq = 0; m_pq = 0; m_clr = 0; m_beep = 0; m_left = 0; tcount = 0;
        end else begin
            sr = s && !m_sq;
            pr = p && !m_pq;
            nclr = 0;
            nbeep = 0;
            if (!e_clrn) tcount = 0;
            else if (e_en) tcount = tcount - 1;
            case (m_st)
                0: if (pr) nclr = 1; else if (sr && d && !td) m_st = 1;
                1: begin
                    if (td) begin
                        m_st = 3;
                        if (BEEP_ON) begin nbeep = 1; m_left = BEEP_CYCLES; end
                    end else if (!d || pr) m_st = 2;
                end
                2: if (pr) begin m_st = 0; nclr = 1; end else if (sr && d) m_st = 1;
                default: begin
                    if (!BEEP_ON || sr || pr) m_st = 0;
                    else begin
                        m_left = m_left - 1;
                        if (m_left == 0) m_st = 0; else nbeep = 1;
                    end
                end
            endcase
            m_clr = nclr; m_beep = nbeep; m_sq = s; m_pq = p;
        end
    endtask

    initial begin
        int n_en, n_beep, n_done;
        bit seen;

        tbl[0]  = mk(0,0,0,1,0, 2'd0, 0,0,0,0);
        tbl[1]  = mk(1,1,0,1,1, 2'd0, 0,0,1,0);
        tbl[2]  = mk(1,0,0,1,0, 2'd0, 0,0,1,0);
        tbl[3]  = mk(1,1,0,0,0, 2'd0, 0,0,1,0);
        tbl[4]  = mk(1,0,0,1,0, 2'd0, 0,0,1,0);
        tbl[5]  = mk(1,1,0,1,0, 2'd0, 0,0,1,0);
        tbl[6]  = mk(1,1,0,1,0, 2'd1, 1,1,1,0);
        tbl[7]  = mk(1,0,0,1,0, 2'd1, 1,1,1,0);
        tbl[8]  = mk(1,0,0,1,1, 2'd1, 1,0,1,0);
        tbl[9]  = mk(1,0,0,1,1, 2'd3, 0,0,1,BEEP_ON);
        tbl[10] = mk(1,1,0,1,1, BEEP_ON ? 2'd3 : 2'd0, 0,0,1,BEEP_ON);
        tbl[11] = mk(1,0,1,1,1, 2'd0, 0,0,1,0);
        tbl[12] = mk(1,0,0,1,1, 2'd0, 0,0,0,0);
        tbl[13] = mk(1,0,0,1,1, 2'd0, 0,0,1,0);
        tbl[14] = mk(1,1,0,1,0, 2'd0, 0,0,1,0);
        tbl[15] = mk(1,0,1,1,0, 2'd1, 1,1,1,0);
        tbl[16] = mk(1,0,0,1,0, 2'd2, 0,0,1,0);
        tbl[17] = mk(1,1,1,1,0, 2'd2, 0,0,1,0);
        tbl[18] = mk(1,0,0,1,0, 2'd0, 0,0,0,0);
        tbl[19] = mk(1,0,0,1,0, 2'd0, 0,0,1,0);

        clearn = 0; start = 0; stop = 0; door_closed = 1; timer_done = 0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            clearn = tbl[i].c; start = tbl[i].s; stop = tbl[i].p;
            door_closed = tbl[i].d; timer_done = tbl[i].td;
            #1;
            check($sformatf("tbl%0d_state", i), {30'd0, state}, {30'd0, tbl[i].st});
            check($sformatf("tbl%0d_mag", i), {31'd0, mag_on}, {31'd0, tbl[i].mag});
            check($sformatf("tbl%0d_en", i), {31'd0, timer_enable}, {31'd0, tbl[i].en});
            check($sformatf("tbl%0d_clrn", i), {31'd0, timer_clearn}, {31'd0, tbl[i].clrn});
            check($sformatf("tbl%0d_beep", i), {31'd0, beep}, {31'd0, tbl[i].bp});
        end

        // normal cook from 0:03
        do_reset(); tcount = 3;
        step(1, 0, 1, 1);
        n_en = 0; n_beep = 0; n_done = 0; seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step(0, 0, 1, 1);
            n_en += int'(a_en); n_beep += int'(a_beep); n_done += int'(a_st == 2'd3);
            if (a_st == 2'd0 && n_done > 0) seen = 1;
        end
        check("cook_back_to_idle", {31'd0, seen}, 1);
        check("cook_enable_cycles", n_en, 3);
        check("cook_beep_cycles", n_beep, BEEP_ON ? BEEP_CYCLES : 0);
        check("cook_done_cycles", n_done, BEEP_ON ? BEEP_CYCLES : 1);

        // door opened mid-cook, then resumed
        do_reset(); tcount = 5;
        step(1, 0, 1, 1);
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check("door_paused", {30'd0, a_st}, 2);
        step(1, 0, 1, 1);
        n_en = 0; seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step(0, 0, 1, 1);
            n_en += int'(a_en);
            if (a_st == 2'd3) seen = 1;
        end
        check("door_done_seen", {31'd0, seen}, 1);
        check("door_remaining_count", n_en, 3);

        // stop twice
        do_reset(); tcount = 4;
        step(1, 0, 1, 1);
        step(0, 0, 1, 1);
        step(0, 1, 1, 1);
        step(0, 0, 1, 1);
        check("stop1_pause", {30'd0, a_st}, 2);
        check("stop1_no_clear", {31'd0, a_clrn}, 1);
        step(0, 1, 1, 1);
        step(0, 0, 1, 1);
        check("stop2_idle", {30'd0, a_st}, 0);
        check("stop2_clear_low", {31'd0, a_clrn}, 0);
        step(0, 0, 1, 1);
        check("stop2_clear_one_cycle", {31'd0, a_clrn}, 1);

        // start and stop together in PAUSE: stop wins
        do_reset(); tcount = 4;
        step(1, 0, 1, 1);
        step(0, 1, 1, 1);
        step(0, 0, 1, 1);
        step(1, 1, 1, 1);
        step(0, 0, 1, 1);
        check("both_keys_idle", {30'd0, a_st}, 0);
        check("both_keys_clear", {31'd0, a_clrn}, 0);

        // timer_done and door open together in COOK: done wins
        do_reset(); tcount = 1;
        step(1, 0, 1, 1);
        step(0, 0, 1, 1);
        step(0, 0, 0, 1);
        step(0, 0, 1, 1);
        check("done_over_door", {30'd0, a_st}, 3);

        // reset while DONE is beeping
        do_reset(); tcount = 1;
        step(1, 0, 1, 1);
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);
        step(0, 0, 1, 0);
        check("rst_clear_low", {31'd0, a_clrn}, 0);
        step(0, 0, 1, 1);
        check("rst_idle", {30'd0, a_st}, 0);
        check("rst_beep_off", {31'd0, a_beep}, 0);

        // randomized run against the model
        do_reset(); tcount = 3;
        for (int k = 0; k < 1500; k++) begin
            if (m_st == 0 && ($urandom % 6) == 0) tcount = $urandom_range(0, 6);
            step(($urandom % 4) == 0, ($urandom % 8) == 0,
                 ($urandom % 10) != 0, ($urandom % 100) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
